// File: rtl/fwft_small_fifo_pkg.sv
// -----------------------------------------------------------------------------
// fwft_small_fifo_pkg
// Shared constants and helpers for the small first-word-fall-through FIFO.
//   DEFAULT_WIDTH          : default data word width (72 bits)
//   DEFAULT_MAX_DEPTH_BITS : default log2 of the FIFO depth (3 -> 8 entries)
//   fifo_depth()           : number of storage entries for a given log2 depth
// -----------------------------------------------------------------------------
package fwft_small_fifo_pkg;

    localparam int DEFAULT_WIDTH          = 72;
    localparam int DEFAULT_MAX_DEPTH_BITS = 3;

    // Depth is always a power of two so the pointers wrap naturally.
    function automatic int fifo_depth(input int depthBits);
        return 1 << depthBits;
    endfunction

endpackage

// File: rtl/fwft_small_fifo.sv
// -----------------------------------------------------------------------------
// fwft_small_fifo
// Small synchronous first-word-fall-through FIFO used as an elastic buffer
// between datapath stages. The head word is always presented on dout while the
// FIFO is non-empty; rd_en acknowledges (pops) it.
//
// Parameters:
//   WIDTH          : data word width
//   MAX_DEPTH_BITS : log2 of the depth (depth = 2**MAX_DEPTH_BITS)
//   NEARLY_FULL    : occupancy at or above which nearly_full asserts
//
// Ports:
//   clk         : sole clock, rising edge
//   reset       : synchronous active-high reset (empties the FIFO)
//   din         : write data
//   wr_en       : push din this cycle
//   rd_en       : pop the current head word this cycle
//   dout        : head word, valid whenever empty = 0
//   full        : occupancy == depth
//   nearly_full : occupancy >= NEARLY_FULL
//   empty       : occupancy == 0
//   overflow    : (only with FWFT_FIFO_ERR_FLAGS_EN) pulse after a dropped write
//   underflow   : (only with FWFT_FIFO_ERR_FLAGS_EN) pulse after a read while empty
//
// Build option: define FWFT_FIFO_ERR_FLAGS_EN to add the overflow/underflow
// outputs. Without it, dropped operations leave no trace.
// -----------------------------------------------------------------------------
module fwft_small_fifo
    import fwft_small_fifo_pkg::*;
#(
    parameter int WIDTH          = DEFAULT_WIDTH,
    parameter int MAX_DEPTH_BITS = DEFAULT_MAX_DEPTH_BITS,
    parameter int NEARLY_FULL    = fifo_depth(MAX_DEPTH_BITS) - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             nearly_full,
`ifdef FWFT_FIFO_ERR_FLAGS_EN
    output logic             overflow,
    output logic             underflow,
`endif
    output logic             empty
);

    localparam int DEPTH = fifo_depth(MAX_DEPTH_BITS);
    localparam logic [MAX_DEPTH_BITS:0]   DEPTH_CNT = (MAX_DEPTH_BITS + 1)'(DEPTH);
    localparam logic [MAX_DEPTH_BITS-1:0] PTR_ONE   = MAX_DEPTH_BITS'(1);
    localparam logic [MAX_DEPTH_BITS:0]   CNT_ONE   = (MAX_DEPTH_BITS + 1)'(1);

    logic [WIDTH-1:0]          mem_q [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wrPtr_q, wrPtr_d;
    logic [MAX_DEPTH_BITS-1:0] rdPtr_q, rdPtr_d;
    logic [MAX_DEPTH_BITS:0]   count_q, count_d;
    logic                      wrAccept;
    logic                      rdAccept;

    // Status flags are pure decodes of the occupancy counter.
    assign empty       = (count_q == '0);
    assign full        = (count_q == DEPTH_CNT);
    assign nearly_full = (int'(count_q) >= NEARLY_FULL);

    // A write into a full FIFO is still legal when the head is popped in the
    // same cycle, because the slot it frees is the one the write lands in.
    assign rdAccept = rd_en && !empty;
    assign wrAccept = wr_en && (!full || rdAccept);

    // Fall-through: the head entry drives dout with no read latency.
    assign dout = mem_q[rdPtr_q];

    // Next-state for pointers and occupancy; a simultaneous push and pop
    // leaves the count unchanged.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (wrAccept) begin
            wrPtr_d = wrPtr_q + PTR_ONE;
        end
        if (rdAccept) begin
            rdPtr_d = rdPtr_q + PTR_ONE;
        end
        case ({wrAccept, rdAccept})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset discards all contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage array has no reset; a write presented during reset is ignored.
    always_ff @(posedge clk) begin
        if (wrAccept && !reset) begin
            mem_q[wrPtr_q] <= din;
        end
    end

`ifdef FWFT_FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    // One-cycle pulses flagging operations that were dropped the cycle before.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= wr_en && full && !rd_en;
            underflow_q <= rd_en && empty;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fwft_small_fifo.sv
// -----------------------------------------------------------------------------
// tb_fwft_small_fifo
// Self-checking bench for fwft_small_fifo (default parameters: 72-bit words,
// 8 entries). Expected behaviour comes from a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_fwft_small_fifo;

    localparam int WIDTH = 72;
    localparam int DEPTH = 8;
    localparam int NEARLY_FULL = DEPTH - 1;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] din;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             nearly_full;
    logic             empty;
`ifdef FWFT_FIFO_ERR_FLAGS_EN
    logic             overflow;
    logic             underflow;
    logic             expOverflow;
    logic             expUnderflow;
`endif

    logic [WIDTH-1:0] model [$];
    int               checks;
    int               errors;

    fwft_small_fifo dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .dout        (dout),
        .full        (full),
        .nearly_full (nearly_full),
`ifdef FWFT_FIFO_ERR_FLAGS_EN
        .overflow    (overflow),
        .underflow   (underflow),
`endif
        .empty       (empty)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs on the falling edge, then apply the FIFO rules
    // to the reference queue at the rising edge.
    task automatic applyStimulus(input logic rst, input logic wr, input logic rd,
                                 input logic [WIDTH-1:0] data);
        int  size;
        bit  rdOk;
        bit  wrOk;
        @(negedge clk);
        reset = rst;
        wr_en = wr;
        rd_en = rd;
        din   = data;
        @(posedge clk);
        size = model.size();
        if (rst) begin
            model.delete();
`ifdef FWFT_FIFO_ERR_FLAGS_EN
            expOverflow  = 1'b0;
            expUnderflow = 1'b0;
`endif
        end else begin
            rdOk = rd && (size > 0);
            wrOk = wr && ((size < DEPTH) || rdOk);
            if (rdOk) void'(model.pop_front());
            if (wrOk) model.push_back(data);
`ifdef FWFT_FIFO_ERR_FLAGS_EN
            expOverflow  = wr && (size == DEPTH) && !rd;
            expUnderflow = rd && (size == 0);
`endif
        end
        #1;
    endtask

    // Compare DUT outputs with the reference model just after the clock edge.
    task automatic checkOutput(input string tag);
        logic expEmpty;
        logic expFull;
        logic expNearly;
        expEmpty  = (model.size() == 0);
        expFull   = (model.size() == DEPTH);
        expNearly = (model.size() >= NEARLY_FULL);

        checks++;
        assert (empty === expEmpty) else begin
            errors++;
            $error("[TB] FAIL %s empty observed=%0b expected=%0b", tag, empty, expEmpty);
        end
        checks++;
        assert (full === expFull) else begin
            errors++;
            $error("[TB] FAIL %s full observed=%0b expected=%0b", tag, full, expFull);
        end
        checks++;
        assert (nearly_full === expNearly) else begin
            errors++;
            $error("[TB] FAIL %s nearly_full observed=%0b expected=%0b", tag, nearly_full, expNearly);
        end
        if (model.size() > 0) begin
            checks++;
            assert (dout === model[0]) else begin
                errors++;
                $error("[TB] FAIL %s dout observed=%h expected=%h", tag, dout, model[0]);
            end
        end
`ifdef FWFT_FIFO_ERR_FLAGS_EN
        checks++;
        assert (overflow === expOverflow) else begin
            errors++;
            $error("[TB] FAIL %s overflow observed=%0b expected=%0b", tag, overflow, expOverflow);
        end
        checks++;
        assert (underflow === expUnderflow) else begin
            errors++;
            $error("[TB] FAIL %s underflow observed=%0b expected=%0b", tag, underflow, expUnderflow);
        end
`endif
    endtask

    function automatic logic [WIDTH-1:0] randomWord();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[WIDTH-1:0];
    endfunction

    initial begin
        logic [WIDTH-1:0] w;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        din    = '0;
`ifdef FWFT_FIFO_ERR_FLAGS_EN
        expOverflow  = 1'b0;
        expUnderflow = 1'b0;
`endif

        // Reset, then idle for five cycles.
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkOutput("reset");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, '0);
            checkOutput("idle");
        end

        // Single write, then single read.
        applyStimulus(1'b0, 1'b1, 1'b0, WIDTH'(8'h11));
        checkOutput("single_write");
        applyStimulus(1'b0, 1'b0, 1'b1, '0);
        checkOutput("single_read");

        // Fill to full, attempt a ninth write, then drain in order.
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, WIDTH'(i));
            checkOutput("fill");
        end
        applyStimulus(1'b0, 1'b1, 1'b0, WIDTH'(8'h09));
        checkOutput("write_when_full");
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("after_drop");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, '0);
            checkOutput("drain");
        end

        // Simultaneous push and pop while full.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, WIDTH'(8'h21 + i));
            checkOutput("refill");
        end
        applyStimulus(1'b0, 1'b1, 1'b1, WIDTH'(8'hAA));
        checkOutput("push_pop_full");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, '0);
            checkOutput("drain_aa");
        end

        // Simultaneous push and pop while empty, then a lone read while empty.
        applyStimulus(1'b0, 1'b1, 1'b1, WIDTH'(8'h55));
        checkOutput("push_pop_empty");
        applyStimulus(1'b0, 1'b0, 1'b1, '0);
        checkOutput("pop_55");
        applyStimulus(1'b0, 1'b0, 1'b1, '0);
        checkOutput("read_when_empty");
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("after_underflow");

        // Mid-operation reset with a write presented in the reset cycle.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, randomWord());
            checkOutput("prefill");
        end
        applyStimulus(1'b1, 1'b1, 1'b0, randomWord());
        checkOutput("reset_midop");

        // Random push/pop traffic spanning pointer wrap-around.
        for (int i = 0; i < 60; i++) begin
            w = randomWord();
            applyStimulus(1'b0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1), w);
            checkOutput("random");
        end
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, '0);
            checkOutput("final_drain");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
